dac_loader: RTL and testbench

- Downstream consumer of the 8 front-panel voltage counters; pushes their values to an 8-channel 8-bit serial DAC (AD5308-class).
- Keeps a shadow copy of the last value sent per channel and re-sends only channels whose value changed.
- Sits between the counter bank and the DAC pins on the pattern-generator board.

---
 rtl/dac_loader.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_dac_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_loader.sv
// dac_loader
// ----------
// Pushes the low bytes of the 8 front-panel voltage counters to an 8-channel,
// 8-bit serial DAC (AD5308-class). A shadow copy of the last value sent is
// kept per channel, and only channels whose value differs from their shadow
// are re-sent. Pending channels are served lowest index first.
//
// Frame on the wire (MSB first, 16 bits while cs_n is low):
//     {1'b0, ch[2:0], data[7:0], 4'b0000}
// The DAC samples mosi on the falling edge of sclk. mosi changes only while
// sclk rises.
//
// Optional build macro: DAC_LOADER_SYNC_LDAC_EN
//     defined   : ldac_n idles high. After a burst of frames, once the gap
//                 following the last frame ends with nothing pending, ldac_n
//                 pulses low for 2*CLK_DIV cycles so all channels update
//                 together.
//     undefined : ldac_n is tied low, so each channel updates on its own
//                 cs_n rise.
//
// Parameters:
//     CLK_DIV  clk cycles per sclk half-period (>= 2)
//     GAP_HP   minimum cs_n-high time between frames, in sclk half-periods
//
// Ports:
//     clk            system clock, all logic on posedge
//     rst            synchronous reset, active-high
//     cntr0..cntr7   counter values, only bits [7:0] are used
//     force_all      single-cycle pulse, marks every channel for resend
//     sclk           DAC serial clock, idles high
//     mosi           DAC serial data
//     cs_n           DAC frame select (SYNC), active-low
//     ldac_n         DAC load strobe, active-low
//     busy           high from frame start until the sequencer is idle again
//     pending        per-channel resend-needed flags
module dac_loader #(
    parameter int CLK_DIV = 4,
    parameter int GAP_HP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cntr0,
    input  logic [15:0] cntr1,
    input  logic [15:0] cntr2,
    input  logic [15:0] cntr3,
    input  logic [15:0] cntr4,
    input  logic [15:0] cntr5,
    input  logic [15:0] cntr6,
    input  logic [15:0] cntr7,
    input  logic        force_all,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        ldac_n,
    output logic        busy,
    output logic [7:0]  pending
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
`ifdef DAC_LOADER_SYNC_LDAC_EN
    localparam logic [1:0] ST_LDAC  = 2'd3;
`endif

    // Terminal counts for the shared cycle counter.
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_HP * CLK_DIV - 1);
`ifdef DAC_LOADER_SYNC_LDAC_EN
    localparam logic [15:0] LDAC_LAST = 16'(2 * CLK_DIV - 1);
`endif

    // ------------------------------------------------------------------
    // Counter inputs: keep the low byte, discard the rest.
    // ------------------------------------------------------------------
    logic [127:0] cntr_all;
    logic [7:0]   cntr_lo [8];
    logic [7:0]   unused_hi;
    logic [7:0]   diff;

    logic [1:0]   state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [4:0]   hp_q, hp_d;        // sclk half-period index within a frame
    logic [15:0]  shift_q, shift_d;
    logic         sclk_q, sclk_d;
    logic         mosi_q, mosi_d;
    logic         cs_n_q, cs_n_d;
    logic         busy_q, busy_d;
    logic [7:0]   pending_q, pending_d;
    logic [7:0]   shadow_q [8];
    logic [7:0]   shadow_d [8];
`ifdef DAC_LOADER_SYNC_LDAC_EN
    logic         ldac_n_q, ldac_n_d;
    logic         sent_q, sent_d;    // a frame went out since the last LDAC pulse
`endif

    assign cntr_all = {cntr7, cntr6, cntr5, cntr4, cntr3, cntr2, cntr1, cntr0};

    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
        assign cntr_lo[gi]   = cntr_all[gi*16 +: 8];
        assign unused_hi[gi] = ^cntr_all[gi*16 + 8 +: 8];
        assign diff[gi]      = (cntr_lo[gi] != shadow_q[gi]);
    end

    // ------------------------------------------------------------------
    // Lowest-index pending channel and its current data.
    // ------------------------------------------------------------------
    logic [2:0]  sel_ch;
    logic [7:0]  sel_data;
    logic [15:0] sel_frame;

    always_comb begin
        sel_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_ch = 3'(i);
            end
        end
    end

    assign sel_data  = cntr_lo[sel_ch];
    assign sel_frame = {1'b0, sel_ch, sel_data, 4'b0000};

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic       start;
    logic [7:0] pending_clr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hp_d        = hp_q;
        shift_d     = shift_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        busy_d      = busy_q;
        shadow_d    = shadow_q;
        pending_clr = 8'h00;
        start       = 1'b0;
`ifdef DAC_LOADER_SYNC_LDAC_EN
        ldac_n_d    = ldac_n_q;
        sent_d      = sent_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    start = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 16'd0;
                    hp_d  = hp_q + 5'd1;
                    if (!hp_q[0]) begin
                        // Even half-period boundary: falling edge, DAC samples.
                        sclk_d = 1'b0;
                    end else begin
                        sclk_d = 1'b1;
                        if (hp_q == 5'd31) begin
                            // Rise after the 16th fall closes the frame.
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                            state_d = ST_GAP;
                        end else begin
                            shift_d = {shift_q[14:0], 1'b0};
                            mosi_d  = shift_q[14];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 16'd0;
                    if (|pending_q) begin
                        // Start the next frame directly so the gap is exact.
                        start = 1'b1;
`ifdef DAC_LOADER_SYNC_LDAC_EN
                    end else if (sent_q) begin
                        state_d  = ST_LDAC;
                        ldac_n_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

`ifdef DAC_LOADER_SYNC_LDAC_EN
            ST_LDAC: begin
                if (cnt_q == LDAC_LAST) begin
                    cnt_d    = 16'd0;
                    ldac_n_d = 1'b1;
                    sent_d   = 1'b0;
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (start) begin
            state_d             = ST_SHIFT;
            cnt_d               = 16'd0;
            hp_d                = 5'd0;
            shift_d             = sel_frame;
            mosi_d              = sel_frame[15];
            sclk_d              = 1'b1;
            cs_n_d              = 1'b0;
            busy_d              = 1'b1;
            shadow_d[sel_ch]    = sel_data;
            pending_clr[sel_ch] = 1'b1;
`ifdef DAC_LOADER_SYNC_LDAC_EN
            sent_d              = 1'b1;
`endif
        end

        // The channel being started compares against its old shadow this
        // cycle, so its clear must win over the change-detect set. force_all
        // wins over everything, including the channel just started.
        if (force_all) begin
            pending_d = 8'hFF;
        end else begin
            pending_d = (pending_q | diff) & ~pending_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            hp_q      <= 5'd0;
            shift_q   <= 16'd0;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            pending_q <= 8'hFF;
            shadow_q  <= '{default: 8'h00};
`ifdef DAC_LOADER_SYNC_LDAC_EN
            ldac_n_q  <= 1'b1;
            sent_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            shift_q   <= shift_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
`ifdef DAC_LOADER_SYNC_LDAC_EN
            ldac_n_q  <= ldac_n_d;
            sent_q    <= sent_d;
`endif
        end
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign pending = pending_q;
`ifdef DAC_LOADER_SYNC_LDAC_EN
    assign ldac_n  = ldac_n_q;
`else
    assign ldac_n  = 1'b0;
`endif

endmodule

// File: tb/tb_dac_loader.sv
// Testbench for dac_loader: directed sequence with randomized counter values,
// frames decoded from the serial pins and compared against a channel-level
// model of what should have been sent.
module tb_dac_loader;

    localparam int CLK_DIV = 4;
    localparam int GAP_HP  = 2;
    localparam int LOW_CYC = 32 * CLK_DIV;
    localparam int GAP_CYC = GAP_HP * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        force_all = 1'b0;
    logic [15:0] cntr [8];
    logic        sclk, mosi, cs_n, ldac_n, busy;
    logic [7:0]  pending;

    dac_loader #(.CLK_DIV(CLK_DIV), .GAP_HP(GAP_HP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cntr0     (cntr[0]),
        .cntr1     (cntr[1]),
        .cntr2     (cntr[2]),
        .cntr3     (cntr[3]),
        .cntr4     (cntr[4]),
        .cntr5     (cntr[5]),
        .cntr6     (cntr[6]),
        .cntr7     (cntr[7]),
        .force_all (force_all),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .ldac_n    (ldac_n),
        .busy      (busy),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Pin monitor: decodes frames as the DAC would see them.
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] word;
        int          bits;
        int          low;
        int          gap;
    } frame_t;

    frame_t frames [$];
    int     ldac_w [$];

    int          cyc = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_ldac = 1'b1;
    logic        in_frame = 1'b0;
    int          fall_cyc = 0, rise_cyc = 0, ldac_start = 0, nb = 0, gap_now = 0;
    logic [15:0] sh = 16'h0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (prev_cs === 1'b1 && cs_n === 1'b0) begin
                gap_now  = cyc - rise_cyc;
                fall_cyc = cyc;
                sh       = 16'h0;
                nb       = 0;
                in_frame = 1'b1;
            end
            if (in_frame && cs_n === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0) begin
                sh = {sh[14:0], mosi};
                nb++;
            end
            if (prev_cs === 1'b0 && cs_n === 1'b1) begin
                if (in_frame) begin
                    frames.push_back('{word: sh, bits: nb, low: cyc - fall_cyc, gap: gap_now});
                end
                in_frame = 1'b0;
                rise_cyc = cyc;
            end
            if (prev_ldac === 1'b1 && ldac_n === 1'b0) ldac_start = cyc;
            if (prev_ldac === 1'b0 && ldac_n === 1'b1) ldac_w.push_back(cyc - ldac_start);
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_ldac = ldac_n;
    end

    // ------------------------------------------------------------------
    // Checking and reference model
    // ------------------------------------------------------------------
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [7:0]  mdl_shadow [8];
    logic [15:0] exp_words [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk_word(input int ch, input logic [7:0] d);
        return {1'b0, 3'(ch), d, 4'b0000};
    endfunction

    // Channels whose counter byte differs from what the DAC last received,
    // in ascending index order; the DAC then holds the new values.
    task automatic model_expect();
        exp_words.delete();
        for (int i = 0; i < 8; i++) begin
            if (cntr[i][7:0] != mdl_shadow[i]) begin
                exp_words.push_back(mk_word(i, cntr[i][7:0]));
                mdl_shadow[i] = cntr[i][7:0];
            end
        end
    endtask

    // Every channel is sent regardless of shadow (reset reload / force_all).
    task automatic model_all();
        for (int i = 0; i < 8; i++) begin
            exp_words.push_back(mk_word(i, cntr[i][7:0]));
            mdl_shadow[i] = cntr[i][7:0];
        end
    endtask

    task automatic wait_quiet(input string tag);
        int quiet = 0;
        int n = 0;
        tick(2);
        while (quiet < 4 && n < 20000) begin
            tick(1);
            n++;
            if (busy === 1'b0 && pending === 8'h00 && cs_n === 1'b1) quiet++;
            else quiet = 0;
        end
        check({tag, "_quiet"}, 32'(quiet >= 4), 32'd1);
    endtask

    task automatic wait_cs_low(input string tag);
        int n = 0;
        while (cs_n !== 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        check({tag, "_cs_fall"}, 32'(cs_n), 32'd0);
    endtask

    task automatic check_burst(input string tag);
        check({tag, "_nframes"}, 32'(frames.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size(); i++) begin
            if (i < frames.size()) begin
                check($sformatf("%s_word%0d", tag, i), 32'(frames[i].word), 32'(exp_words[i]));
                check($sformatf("%s_bits%0d", tag, i), 32'(frames[i].bits), 32'd16);
                check($sformatf("%s_low%0d", tag, i), 32'(frames[i].low), 32'(LOW_CYC));
                if (i > 0) begin
                    check($sformatf("%s_gap%0d", tag, i), 32'(frames[i].gap), 32'(GAP_CYC));
                end
            end
        end
`ifdef DAC_LOADER_SYNC_LDAC_EN
        check({tag, "_ldac_pulses"}, 32'(ldac_w.size()), 32'(exp_words.size() > 0 ? 1 : 0));
        for (int i = 0; i < ldac_w.size(); i++) begin
            check($sformatf("%s_ldac_w%0d", tag, i), 32'(ldac_w[i]), 32'(2 * CLK_DIV));
        end
`else
        check({tag, "_ldac_pulses"}, 32'(ldac_w.size()), 32'd0);
        check({tag, "_ldac_low"}, 32'(ldac_n), 32'd0);
`endif
        $display("burst %s: %0d frames seen, %0d expected", tag, frames.size(), exp_words.size());
        frames.delete();
        ldac_w.delete();
        exp_words.delete();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] v;
        logic        exp_ldac_rst;
`ifdef DAC_LOADER_SYNC_LDAC_EN
        exp_ldac_rst = 1'b1;
`else
        exp_ldac_rst = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            cntr[i]       = 16'h0000;
            mdl_shadow[i] = 8'h00;
        end

        // Reset state.
        rst = 1'b1;
        tick(3);
        check("rst_cs_n",    32'(cs_n),    32'd1);
        check("rst_sclk",    32'(sclk),    32'd1);
        check("rst_mosi",    32'(mosi),    32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_pending", 32'(pending), 32'hFF);
        check("rst_ldac_n",  32'(ldac_n),  32'(exp_ldac_rst));

        // Post-reset reload: all 8 channels with data 0.
        rst = 1'b0;
        frames.delete();
        ldac_w.delete();
        model_all();
        wait_quiet("reload");
        check("reload_pending", 32'(pending), 32'h00);
        check_burst("reload");

        // Latency and word format: cntr2 = 0x0051 while idle.
        cntr[2] = 16'h0051;
        tick(1);
        check("lat_cs_1clk",    32'(cs_n),    32'd1);
        check("lat_pending",    32'(pending), 32'h04);
        tick(1);
        check("lat_cs_2clk",    32'(cs_n),    32'd0);
        check("lat_busy",       32'(busy),    32'd1);
        model_expect();
        wait_quiet("ch2");
        if (frames.size() > 0) check("ch2_word_2510", 32'(frames[0].word), 32'h2510);
        check_burst("ch2");

        // Value changes during its own frame.
        cntr[0] = 16'h0066;
        wait_cs_low("own");
        tick(10);
        cntr[0] = 16'h0067;
        tick(2);
        check("own_pending0", 32'(pending[0]), 32'd1);
        check("own_still_low", 32'(cs_n), 32'd0);
        exp_words.delete();
        exp_words.push_back(16'h0660);
        exp_words.push_back(16'h0670);
        mdl_shadow[0] = 8'h67;
        wait_quiet("own");
        check_burst("own");

        // Two channels change on the same clock: 1 before 5.
        v = 16'($urandom); v[7:0] = 8'($urandom_range(1, 255)); cntr[5] = v;
        v = 16'($urandom); v[7:0] = 8'($urandom_range(1, 255)); cntr[1] = v;
        model_expect();
        wait_quiet("pair");
        check_burst("pair");

        // Random multi-channel updates.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 1) == 1) cntr[i] = 16'($urandom);
            end
            model_expect();
            wait_quiet($sformatf("rand%0d", it));
            check_burst($sformatf("rand%0d", it));
        end

        // force_all during a frame: current frame finishes, then all 8.
        v = cntr[4];
        v[7:0] = mdl_shadow[4] + 8'd1;
        cntr[4] = v;
        model_expect();
        wait_cs_low("force");
        tick(20);
        force_all = 1'b1;
        tick(1);
        force_all = 1'b0;
        model_all();
        wait_quiet("force");
        check_burst("force");

        // Reset mid-frame, at bit 7 while mosi carries a data 1.
        cntr[6] = (mdl_shadow[6] == 8'hFF) ? 16'h00FE : 16'h00FF;
        wait_cs_low("midrst");
        tick(13 * CLK_DIV + 1);
        check("midrst_mosi_hi", 32'(mosi), 32'd1);
        rst = 1'b1;
        tick(1);
        check("midrst_cs_n",    32'(cs_n),    32'd1);
        check("midrst_sclk",    32'(sclk),    32'd1);
        check("midrst_mosi",    32'(mosi),    32'd0);
        check("midrst_pending", 32'(pending), 32'hFF);
        check("midrst_busy",    32'(busy),    32'd0);
        tick(1);
        rst = 1'b0;
        frames.delete();
        ldac_w.delete();
        exp_words.delete();
        model_all();
        wait_quiet("rerun");
        check_burst("rerun");

        // Counter decremented below zero: plain truncation to 0xFF.
        cntr[3] = 16'h0000;
        model_expect();
        wait_quiet("ch3zero");
        check_burst("ch3zero");
        cntr[3] = 16'hFFFF;
        model_expect();
        wait_quiet("ch3ffff");
        if (frames.size() > 0) check("ch3_word_3ff0", 32'(frames[0].word), 32'h3FF0);
        check_burst("ch3ffff");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
